// File: rtl/act_pwl_unit_pkg.sv
// Shared fixed-point format and coefficient-entry definitions for the PWL activation unit.
package act_pwl_unit_pkg;

   localparam int Q_INT         = 4;
   localparam int Q_FRAC        = 12;
   localparam int Q_SIZE        = Q_INT + Q_FRAC;
   localparam int ACT_LUT_DEPTH = 6;
   localparam int NU_COUNT      = 4;

   typedef struct packed {
      logic signed [Q_SIZE-1:0] a;
      logic signed [Q_SIZE-1:0] b;
   } lut_entry_t;

endpackage

// File: rtl/act_pwl_unit_if.sv
// Valid/ready stream bundle carrying packed activation lanes in and out of the unit.
interface act_pwl_unit_if
   import act_pwl_unit_pkg::*;
#(
   parameter int LANES  = NU_COUNT,
   parameter int LANE_W = Q_SIZE
);

   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*LANE_W-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*LANE_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/act_pwl_lut.sv
// Banked slope/intercept table: one synchronous read port per lane, one write port.
// Read-before-write, so a read and a write to the same entry on one edge returns the old entry.
module act_pwl_lut
   import act_pwl_unit_pkg::*;
#(
   parameter int  LANES   = NU_COUNT,
   parameter int  DEPTH_W = ACT_LUT_DEPTH,
   parameter int  BANKS   = 2,
   parameter int  ENTRY_W = $bits(lut_entry_t),
   localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int ENTRIES = BANKS * (1 << DEPTH_W)
)(
   input  logic                       clk,
   input  logic                       rd_en,
   input  logic [BANK_W-1:0]          rd_bank,
   input  logic [LANES*DEPTH_W-1:0]   rd_seg,
   output logic [LANES*ENTRY_W-1:0]   rd_data,
   input  logic                       wr_en,
   input  logic [BANK_W-1:0]          wr_bank,
   input  logic [DEPTH_W-1:0]         wr_seg,
   input  logic [ENTRY_W-1:0]         wr_data
);

   logic [ENTRY_W-1:0] mem_r [ENTRIES];

   function automatic logic bank_ok(input logic [BANK_W-1:0] bank);
      return ({1'b0, bank} < (BANK_W + 1)'(BANKS));
   endfunction

   // Coefficient write port; contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en && bank_ok(wr_bank)) begin
         mem_r[{wr_bank, wr_seg}] <= wr_data;
      end
   end

   // Per-lane registered reads, frozen while the pipeline is stalled.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         for (int l = 0; l < LANES; l++) begin
            if (bank_ok(rd_bank)) begin
               rd_data[l*ENTRY_W +: ENTRY_W] <= mem_r[{rd_bank, rd_seg[l*DEPTH_W +: DEPTH_W]}];
            end else begin
               rd_data[l*ENTRY_W +: ENTRY_W] <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/act_pwl_unit.sv
// act_pwl_unit: y = a[i]*x + b[i] per lane, 3-stage stallable pipeline (index, LUT read, multiply-add).
// Build option ACT_PWL_SAT_EN saturates results; otherwise they wrap to Q_SIZE bits.
module act_pwl_unit #(
   parameter int  LANES     = act_pwl_unit_pkg::NU_COUNT,
   parameter int  Q_INT     = act_pwl_unit_pkg::Q_INT,
   parameter int  Q_FRAC    = act_pwl_unit_pkg::Q_FRAC,
   parameter int  LUT_DEPTH = act_pwl_unit_pkg::ACT_LUT_DEPTH,
   parameter int  BANKS     = 2,
   localparam int Q_SIZE    = Q_INT + Q_FRAC,
   localparam int BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1
)(
   input  logic                 clk,
   input  logic                 rst,
   act_pwl_unit_if.slave        bus,
   input  logic                 cfg_we,
   input  logic [BANK_W-1:0]    cfg_bank,
   input  logic [LUT_DEPTH-1:0] cfg_addr,
   input  logic [Q_SIZE-1:0]    cfg_a,
   input  logic [Q_SIZE-1:0]    cfg_b,
   input  logic [BANK_W-1:0]    bank_sel,
   output logic                 busy
);

   localparam int ENTRY_W = 2 * Q_SIZE;
   localparam logic [LUT_DEPTH-1:0]        SEG_MSB = LUT_DEPTH'(1) << (LUT_DEPTH - 1);
   localparam logic signed [2*Q_SIZE-1:0]  ROUND   = (2*Q_SIZE)'(1) << (Q_FRAC - 1);
`ifdef ACT_PWL_SAT_EN
   localparam logic signed [Q_SIZE+1:0]    SAT_MAX = (Q_SIZE+2)'((34'sd1 <<< (Q_SIZE - 1)) - 34'sd1);
   localparam logic signed [Q_SIZE+1:0]    SAT_MIN = ~SAT_MAX;
`endif

   logic                         advance_s;
   logic [LANES*LUT_DEPTH-1:0]   seg_s;
   logic [LANES*ENTRY_W-1:0]     lut_rd_s;
   logic [LANES*Q_SIZE-1:0]      y_s;

   logic                         s1_valid_r;
   logic                         s2_valid_r;
   logic                         s3_valid_r;
   logic [LANES*Q_SIZE-1:0]      s1_x_r;
   logic [LANES*LUT_DEPTH-1:0]   s1_seg_r;
   logic [BANK_W-1:0]            s1_bank_r;
   logic [LANES*Q_SIZE-1:0]      s2_x_r;
   logic [LANES*Q_SIZE-1:0]      s3_data_r;

   logic signed [Q_SIZE-1:0]     x_s;
   logic signed [Q_SIZE-1:0]     a_s;
   logic signed [Q_SIZE-1:0]     b_s;
   logic signed [2*Q_SIZE-1:0]   prod_s;
   logic signed [Q_SIZE+1:0]     sum_s;

   assign advance_s     = !s3_valid_r || bus.out_ready;
   assign bus.in_ready  = advance_s;
   assign bus.out_valid = s3_valid_r;
   assign bus.out_data  = s3_data_r;
   assign busy          = s1_valid_r | s2_valid_r | s3_valid_r;

   // Segment index per lane: top LUT_DEPTH bits with the sign flipped so the most negative x is segment 0.
   always_comb begin
      seg_s = '0;
      for (int l = 0; l < LANES; l++) begin
         seg_s[l*LUT_DEPTH +: LUT_DEPTH] = bus.in_data[l*Q_SIZE + Q_SIZE - LUT_DEPTH +: LUT_DEPTH] ^ SEG_MSB;
      end
   end

   // Stage payloads move only with a valid beat, so stalls and bubbles leave them untouched.
   always_ff @(posedge clk) begin
      if (advance_s && bus.in_valid) begin
         s1_x_r    <= bus.in_data;
         s1_seg_r  <= seg_s;
         s1_bank_r <= bank_sel;
      end
      if (advance_s && s1_valid_r) begin
         s2_x_r <= s1_x_r;
      end
   end

   act_pwl_lut #(
      .LANES   (LANES),
      .DEPTH_W (LUT_DEPTH),
      .BANKS   (BANKS),
      .ENTRY_W (ENTRY_W)
   ) u_lut (
      .clk     (clk),
      .rd_en   (advance_s),
      .rd_bank (s1_bank_r),
      .rd_seg  (s1_seg_r),
      .rd_data (lut_rd_s),
      .wr_en   (cfg_we),
      .wr_bank (cfg_bank),
      .wr_seg  (cfg_addr),
      .wr_data ({cfg_a, cfg_b})
   );

   // Multiply-add: round the 2*Q_SIZE product back to Q_FRAC, then add b with two guard bits.
   always_comb begin
      y_s    = '0;
      x_s    = '0;
      a_s    = '0;
      b_s    = '0;
      prod_s = '0;
      sum_s  = '0;
      for (int l = 0; l < LANES; l++) begin
         x_s    = s2_x_r[l*Q_SIZE +: Q_SIZE];
         a_s    = lut_rd_s[l*ENTRY_W + Q_SIZE +: Q_SIZE];
         b_s    = lut_rd_s[l*ENTRY_W +: Q_SIZE];
         prod_s = (2*Q_SIZE)'(x_s) * (2*Q_SIZE)'(a_s);
         sum_s  = (Q_SIZE+2)'((prod_s + ROUND) >>> Q_FRAC) + (Q_SIZE+2)'(b_s);
`ifdef ACT_PWL_SAT_EN
         if (sum_s > SAT_MAX) begin
            y_s[l*Q_SIZE +: Q_SIZE] = Q_SIZE'(SAT_MAX);
         end else if (sum_s < SAT_MIN) begin
            y_s[l*Q_SIZE +: Q_SIZE] = Q_SIZE'(SAT_MIN);
         end else begin
            y_s[l*Q_SIZE +: Q_SIZE] = Q_SIZE'(sum_s);
         end
`else
         y_s[l*Q_SIZE +: Q_SIZE] = Q_SIZE'(sum_s);
`endif
      end
   end

   // Valid chain and output register; reset drops every in-flight beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s2_valid_r <= 1'b0;
         s3_valid_r <= 1'b0;
         s3_data_r  <= '0;
      end else if (advance_s) begin
         s1_valid_r <= bus.in_valid;
         s2_valid_r <= s1_valid_r;
         s3_valid_r <= s2_valid_r;
         if (s2_valid_r) begin
            s3_data_r <= y_s;
         end
      end
   end

endmodule

// File: tb/tb_act_pwl_unit.sv
// Scoreboard bench for act_pwl_unit: expected beats are queued at acceptance and compared on output.
module tb_act_pwl_unit;
   import act_pwl_unit_pkg::*;

   typedef struct {
      logic [63:0] data;
      int          cyc;
      bit          chk_lat;
   } sb_t;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [0:0]  cfg_bank;
   logic [5:0]  cfg_addr;
   logic [15:0] cfg_a;
   logic [15:0] cfg_b;
   logic [0:0]  bank_sel;
   logic        busy;

   act_pwl_unit_if #(.LANES(4), .LANE_W(16)) bus ();

   act_pwl_unit dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .cfg_we   (cfg_we),
      .cfg_bank (cfg_bank),
      .cfg_addr (cfg_addr),
      .cfg_a    (cfg_a),
      .cfg_b    (cfg_b),
      .bank_sel (bank_sel),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc_n = 0;
   sb_t         sb_q[$];
   lut_entry_t  mdl [2][64];
   bit          ovr_en = 1'b0;
   logic [63:0] ovr_data = 64'h0;
   bit          lat_en = 1'b0;
   bit          last_acc = 1'b0;
   bit          last_in_ready = 1'b0;
   bit          was_stall = 1'b0;
   logic [63:0] hold_data = 64'h0;
   logic [63:0] beats [8];
   int          sent;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_n);
      end
   endtask

   function automatic logic [15:0] pwl_ref(input logic [15:0] x, input lut_entry_t e);
      logic signed [31:0] p;
      logic signed [31:0] r;
      logic signed [17:0] s;
      p = $signed(e.a) * $signed(x);
      r = (p + 32'sd2048) >>> 12;
      s = r[17:0] + {{2{e.b[15]}}, e.b};
`ifdef ACT_PWL_SAT_EN
      if (s > 18'sh07FFF) return 16'h7FFF;
      else if (s < -18'sh08000) return 16'h8000;
      else return s[15:0];
`else
      return s[15:0];
`endif
   endfunction

   function automatic logic [63:0] model_beat(input logic [63:0] xin, input logic [0:0] bank);
      logic [63:0] r;
      logic [15:0] x;
      logic [5:0]  seg;
      r = 64'h0;
      for (int l = 0; l < 4; l++) begin
         x   = xin[l*16 +: 16];
         seg = {~x[15], x[14:10]};
         r[l*16 +: 16] = pwl_ref(x, mdl[bank][seg]);
      end
      return r;
   endfunction

   function automatic logic [63:0] rep4(input logic [15:0] v);
      return {4{v}};
   endfunction

   // One cycle: inputs are already set at the negedge; observe, score, then wait for the next negedge.
   task automatic step();
      sb_t e;
      #1;
      if (!rst) begin
         if (was_stall) begin
            check_val("stall_hold_valid", {63'h0, bus.out_valid}, 64'h1);
            check_val("stall_hold_data", bus.out_data, hold_data);
         end
         if (sb_q.size() == 0) check_val("idle_out_valid", {63'h0, bus.out_valid}, 64'h0);
         if (bus.out_valid && bus.out_ready && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("out_data", bus.out_data, e.data);
            if (e.chk_lat) check_val("latency", 64'(cyc_n - e.cyc), 64'd3);
         end
         if (bus.in_valid && bus.in_ready) begin
            e.data    = ovr_en ? ovr_data : model_beat(bus.in_data, bank_sel);
            e.cyc     = cyc_n;
            e.chk_lat = lat_en;
            sb_q.push_back(e);
         end
         was_stall = bus.out_valid && !bus.out_ready;
         hold_data = bus.out_data;
      end else begin
         was_stall = 1'b0;
      end
      last_acc      = bus.in_valid && bus.in_ready;
      last_in_ready = bus.in_ready;
      if (cfg_we) mdl[cfg_bank][cfg_addr] = '{a: cfg_a, b: cfg_b};
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic send_beat(input logic [63:0] x, input logic [0:0] bank, input bit ovr,
                            input logic [63:0] exp, input bit lat);
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      bank_sel     = bank;
      ovr_en       = ovr;
      ovr_data     = exp;
      lat_en       = lat;
      for (int t = 0; t < 20; t++) begin
         step();
         if (last_acc) break;
      end
      check_val("beat_accepted", {63'h0, last_acc}, 64'h1);
      bus.in_valid = 1'b0;
      ovr_en       = 1'b0;
      lat_en       = 1'b0;
   endtask

   task automatic cfg_write(input logic [0:0] bank, input logic [5:0] addr, input logic [15:0] a,
                            input logic [15:0] b);
      cfg_we = 1'b1; cfg_bank = bank; cfg_addr = addr; cfg_a = a; cfg_b = b;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 30 && sb_q.size() > 0; t++) step();
      check_val("drain_empty", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_bank = 1'b0; cfg_addr = 6'd0; cfg_a = 16'h0; cfg_b = 16'h0;
      bank_sel = 1'b0; bus.in_valid = 1'b0; bus.in_data = 64'h0; bus.out_ready = 1'b1;
      @(negedge clk);
      step();
      step();
      check_val("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check_val("rst_out_data", bus.out_data, 64'h0);
      check_val("rst_busy", {63'h0, busy}, 64'h0);
      rst = 1'b0;
      #1;
      check_val("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
      @(negedge clk);

      // Bank 0 identity slope, bank 1 random coefficients.
      for (int s = 0; s < 64; s++) cfg_write(1'b0, 6'(s), 16'h1000, 16'h0000);
      for (int s = 0; s < 64; s++) cfg_write(1'b1, 6'(s), 16'($urandom), 16'($urandom));

      // Identity: 0x0A00 comes back unchanged, three cycles after acceptance.
      send_beat(rep4(16'h0A00), 1'b0, 1'b1, rep4(16'h0A00), 1'b1);
      drain();

      // Overflow: 4.0 * 3.0 either saturates or wraps.
      cfg_write(1'b1, 6'd44, 16'h4000, 16'h0000);
`ifdef ACT_PWL_SAT_EN
      send_beat(rep4(16'h3000), 1'b1, 1'b1, rep4(16'h7FFF), 1'b1);
`else
      send_beat(rep4(16'h3000), 1'b1, 1'b1, rep4(16'hC000), 1'b1);
`endif
      drain();

      // Rounding plus intercept.
      cfg_write(1'b0, 6'd32, 16'h0800, 16'h0100);
      send_beat(rep4(16'h0001), 1'b0, 1'b1, rep4(16'h0101), 1'b1);
      drain();

      // Back-to-back random beats through the random bank at full throughput.
      for (int i = 0; i < 6; i++) begin
         send_beat({$urandom, $urandom}, 1'b1, 1'b0, 64'h0, 1'b1);
      end
      drain();

      // Output stall in cycles 4-6 of an 8-beat stream, with bank-0 writes during the stall.
      for (int i = 0; i < 8; i++) beats[i] = {$urandom, $urandom};
      sent = 0;
      for (int k = 0; k < 20 && sent < 8; k++) begin
         bus.out_ready = !(k >= 4 && k <= 6);
         bus.in_valid  = 1'b1;
         bus.in_data   = beats[sent];
         bank_sel      = 1'b1;
         cfg_we        = (k >= 4 && k <= 6);
         cfg_bank      = 1'b0;
         cfg_addr      = 6'(k);
         cfg_a         = 16'($urandom);
         cfg_b         = 16'($urandom);
         step();
         check_val("stall_in_ready", {63'h0, last_in_ready}, (k >= 4 && k <= 6) ? 64'h0 : 64'h1);
         if (last_acc) sent++;
      end
      bus.in_valid = 1'b0; cfg_we = 1'b0; bus.out_ready = 1'b1;
      check_val("stream_sent", 64'(sent), 64'd8);
      drain();

      // Bank switch between consecutive beats while bank 0 is rewritten under the first beat's read.
      send_beat(rep4(16'h0A00), 1'b0, 1'b1, rep4(16'h0A00), 1'b0);
      cfg_we = 1'b1; cfg_bank = 1'b0; cfg_addr = 6'd34; cfg_a = 16'h0000; cfg_b = 16'h1234;
      send_beat(rep4(16'h0A00), 1'b1, 1'b0, 64'h0, 1'b0);
      cfg_we = 1'b0;
      send_beat(rep4(16'h0A00), 1'b0, 1'b1, rep4(16'h1234), 1'b0);
      drain();

      // Reset with three beats in flight: none of them may ever emerge.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 1'b0, 1'b0, 64'h0, 1'b0);
      step();
      check_val("busy_inflight", {63'h0, busy}, 64'h1);
      rst = 1'b1;
      sb_q.delete();
      step();
      rst = 1'b0;
      check_val("midrst_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check_val("midrst_busy", {63'h0, busy}, 64'h0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/act_pwl_unit.md
ACT_PWL_UNIT -- requirements
Module: act_pwl_unit

Interface
REQ-001 Parameters SHALL be: LANES, default 4, parallel activation lanes; Q_INT, default 4, integer bits; Q_FRAC, default 12, fraction bits; LUT_DEPTH, default 6, log2 segments; BANKS, default 2, coefficient banks.
REQ-002 Ports: clk  in  1  clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1; in_ready  out  1; in_data  in  LANES*Q_SIZE  signed Q lanes, lane 0 in LSBs.
REQ-005 out_valid  out  1; out_ready  in  1; out_data  out  LANES*Q_SIZE  activated lanes.
REQ-006 cfg_we  in  1; cfg_bank  in  clog2(BANKS); cfg_addr  in  LUT_DEPTH; cfg_a  in  Q_SIZE slope; cfg_b  in  Q_SIZE intercept.
REQ-007 bank_sel  in  clog2(BANKS)  bank used by newly accepted beats; busy  out  1  any pipeline stage valid.

Function
REQ-008 Per lane, y SHALL equal a[i]*x + b[i], with i = x[Q_SIZE-1:Q_SIZE-LUT_DEPTH] and the MSB inverted, so the most negative x maps to segment 0.
REQ-009 Product SHALL be 2*Q_SIZE signed; add 2^(Q_FRAC-1), arithmetic shift right by Q_FRAC, then add sign-extended b at Q_SIZE+2 bits.
REQ-010 Pipeline SHALL be 3 stages: S1 registers x, segment index and bank; S2 synchronous LUT read; S3 multiply-add and output register.
REQ-011 Latency SHALL be 3 cycles from in_valid&&in_ready to out_valid with out_ready held high; throughput one beat per cycle.
REQ-012 Global advance = !out_valid || out_ready; in_ready SHALL equal advance; all stages hold while stalled.
REQ-013 out_data SHALL stay stable while out_valid&&!out_ready.
REQ-014 Bubbles SHALL propagate as invalid stages and SHALL NOT be collapsed.
REQ-015 bank_sel SHALL be sampled per beat at acceptance; changing it never affects beats in flight.
REQ-016 cfg_we SHALL write {a,b} into cfg_bank/cfg_addr for all lanes; the write is visible to S2 reads in the next cycle.
REQ-017 A same-cycle S2 read and write to the same bank/address SHALL return the old entry.
REQ-018 Writes to any bank, active or not, SHALL be legal at any time, including during a stall.
REQ-019 busy SHALL be the OR of the S1, S2 and S3 valid bits.

Reset
REQ-020 On rst: all stage valids = 0, out_valid = 0, out_data = 0, busy = 0.
REQ-021 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-022 LUT contents SHALL NOT be reset.
REQ-023 rst mid-operation SHALL discard all in-flight beats without emitting them.

Configuration
REQ-024 Macro ACT_PWL_SAT_EN: when defined, the S3 result SHALL saturate to [-2^(Q_SIZE-1), 2^(Q_SIZE-1)-1].
REQ-025 Without ACT_PWL_SAT_EN, the result SHALL be truncated to the low Q_SIZE bits (two's-complement wrap).

Structure
REQ-026 Q_INT, Q_FRAC, Q_SIZE, ACT_LUT_DEPTH and the LUT entry struct {a,b} SHALL live in the shared definitions package; the LANES default SHALL be NU_COUNT.
REQ-027 A sub-module act_pwl_lut SHALL hold BANKS*2^LUT_DEPTH entries, with one sync read port per lane and one write port.

Verification
REQ-028 Load bank 0 with a=0x1000, b=0x0000 in all entries; send x=0x0A00 on all lanes -> out 0x0A00 on all lanes exactly 3 cycles later.
REQ-029 Bank 1, segment 44 set to a=0x4000, b=0; bank_sel=1; x=0x3000 -> out 0x7FFF with ACT_PWL_SAT_EN, 0xC000 without.
REQ-030 Stream 8 beats with out_ready low in cycles 4-6 -> in_ready low in the same cycles, no loss or duplication, order preserved, out_data stable while stalled.
REQ-031 Toggle bank_sel 0->1 between consecutive beats while rewriting bank 0 -> first beat uses old bank-0 entry, second beat uses bank 1.
REQ-032 Assert rst with 3 beats in flight -> out_valid=0, busy=0 next cycle; none of those beats ever appears at the output.
REQ-033 Segment 32 set to a=0x0800, b=0x0100; x=0x0001 -> out 0x0101 (product 0x0800 plus rounding 0x800, shifted right by 12, gives 1; plus b 0x0100).
